// File: rtl/voltage_bank_scheduler_pkg.sv
// Shared constants and state encodings for the LCOPA voltage line RAM
// ping-pong bank scheduler.
package voltage_bank_scheduler_pkg;

    localparam int LINE_WORDS = 480;
    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 24;

    // VSYNC is asserted low for the VSPW interval; its falling edge marks frame start.
    localparam logic VSYNC_ACTIVE = 1'b0;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_WORDS - 1);

    typedef enum logic {
        W_FILL = 1'b0,
        W_WAIT = 1'b1
    } wr_state_e;

endpackage

// File: rtl/voltage_bank_scheduler_if.sv
// Host write handshake plus the registered RAM write port of the bank scheduler.
interface voltage_bank_scheduler_if;
    import voltage_bank_scheduler_pkg::*;

    logic              Wr_Valid;
    logic              Wr_Ready;
    logic [DATA_W-1:0] Wr_Data;
    logic              RAMWrEn;
    logic [ADDR_W:0]   RAMWrADD;
    logic [DATA_W-1:0] RAMWrData;

    modport master (
        output Wr_Valid,
        output Wr_Data,
        input  Wr_Ready,
        input  RAMWrEn,
        input  RAMWrADD,
        input  RAMWrData
    );

    modport slave (
        input  Wr_Valid,
        input  Wr_Data,
        output Wr_Ready,
        output RAMWrEn,
        output RAMWrADD,
        output RAMWrData
    );

endinterface

// File: rtl/voltage_bank_scheduler_vsync_edge_sync.sv
// Multi-flop synchroniser with a one-cycle pulse on entry into the active level.
// Generic over polarity so the same block serves VSYNC and HSYNC.
module vsync_edge_sync #(
    parameter int   STAGES     = 2,
    parameter logic ACTIVE_LVL = 1'b0
) (
    input  logic SysClk,
    input  logic Reset_N,
    input  logic Sync_In,
    output logic Edge_Pulse
);

    localparam logic IDLE_LVL = ~ACTIVE_LVL;

    logic [STAGES-1:0] sync_p0;
    logic              last_p1;

    // Resetting to the idle level keeps reset-time activity from looking like an edge.
    always_ff @(posedge SysClk or negedge Reset_N) begin
        if (!Reset_N) begin
            sync_p0 <= {STAGES{IDLE_LVL}};
            last_p1 <= IDLE_LVL;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                sync_p0[i] <= sync_p0[i-1];
            end
            sync_p0[0] <= Sync_In;
            last_p1    <= sync_p0[STAGES-1];
        end
    end

    assign Edge_Pulse = (last_p1 == IDLE_LVL) && (sync_p0[STAGES-1] == ACTIVE_LVL);

endmodule

// File: rtl/voltage_bank_scheduler.sv
// Ping-pong bank controller: the host fills one 480-word bank while the dispatcher
// reads the other; banks swap only on a VSYNC falling edge.
module voltage_bank_scheduler
    import voltage_bank_scheduler_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                           SysClk,
    input  logic                           Reset_N,
    voltage_bank_scheduler_if.slave        Bus,
    input  logic                           Flush,
    input  logic                           VSYNC,
    output logic                           RdBank,
    output logic                           Send,
    output logic                           Underrun,
    output logic [15:0]                    Swap_Count
);

    wr_state_e         state_q;
    wr_state_e         state_nxt;
    logic [ADDR_W-1:0] idx_q;
    logic              pending_q;
    logic              rd_bank_q;
    logic              send_q;
    logic              underrun_q;
    logic [15:0]       swap_cnt_q;

    logic              vs_fall;
    logic              wr_ready;
    logic              accept;
    logic              take;
    logic              last_take;
    logic              swap;

    logic              wr_vld_p1;
    logic [ADDR_W:0]   wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;

    vsync_edge_sync #(
        .STAGES     (SYNC_STAGES),
        .ACTIVE_LVL (VSYNC_ACTIVE)
    ) u_vsync_edge (
        .SysClk     (SysClk),
        .Reset_N    (Reset_N),
        .Sync_In    (VSYNC),
        .Edge_Pulse (vs_fall)
    );

    assign wr_ready  = (state_q == W_FILL);
    assign accept    = Bus.Wr_Valid & wr_ready;
    // Flush drops a word offered in the same cycle so the refill starts clean.
    assign take      = accept & ~Flush;
    assign last_take = take & (idx_q == LAST_IDX);
    // A bank completing on the frame-start cycle itself still counts as ready.
    assign swap      = vs_fall & ~Flush & (pending_q | last_take);

    always_ff @(posedge SysClk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= W_FILL;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            W_FILL: begin
                if (!Flush && !swap && last_take) begin
                    state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (Flush || swap) begin
                    state_nxt = W_FILL;
                end
            end
            default: state_nxt = W_FILL;
        endcase
    end

    // Stage p1: registered RAM write, one cycle behind the accepted word.
    always_ff @(posedge SysClk or negedge Reset_N) begin
        if (!Reset_N) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= take;
            if (take) begin
                wr_addr_p1 <= {~rd_bank_q, idx_q};
                wr_data_p1 <= Bus.Wr_Data;
            end
        end
    end

    always_ff @(posedge SysClk or negedge Reset_N) begin
        if (!Reset_N) begin
            idx_q      <= '0;
            pending_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            send_q     <= 1'b1;
            underrun_q <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            if (Flush) begin
                idx_q <= '0;
            end else if (take) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_W'(1);
            end

            if (Flush || swap) begin
                pending_q <= 1'b0;
            end else if (last_take) begin
                pending_q <= 1'b1;
            end

            if (swap) begin
                rd_bank_q  <= ~rd_bank_q;
                swap_cnt_q <= swap_cnt_q + 16'd1;
                send_q     <= 1'b0;
            end

            // Underrun only counts once the dispatcher has been released to run.
            if (Flush) begin
                underrun_q <= 1'b0;
            end else if (vs_fall && !pending_q && !last_take && !send_q) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign Bus.Wr_Ready  = wr_ready;
    assign Bus.RAMWrEn   = wr_vld_p1;
    assign Bus.RAMWrADD  = wr_addr_p1;
    assign Bus.RAMWrData = wr_data_p1;
    assign RdBank        = rd_bank_q;
    assign Send          = send_q;
    assign Underrun      = underrun_q;
    assign Swap_Count    = swap_cnt_q;

endmodule
